// File: rtl/muldiv_sequencer_if.sv
// Decode <-> HI/LO sequencer connection: op request, HI/LO read request, status and HI/LO values.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, rd_req,
    input  busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_req,
    output busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer: shift-add MULTU, restoring DIVU, MTHI/MTLO.
// Define MULDIV_SIGNED_EN to also accept signed MULT (010) and DIV (011).
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] low_r;
  logic [WIDTH-1:0] operand_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             b_zero_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             legal_s;
  logic             signed_op_s;
  logic             accept_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Op legality and signed-operand detection from the decode request
  always_comb begin
    legal_s     = 1'b0;
    signed_op_s = 1'b0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b101: legal_s = 1'b1;
`ifdef MULDIV_SIGNED_EN
      3'b010, 3'b011: begin
        legal_s     = 1'b1;
        signed_op_s = 1'b1;
      end
`else
      3'b010, 3'b011: legal_s = 1'b0;
`endif
      default: legal_s = 1'b0;
    endcase
  end

  assign a_neg_s  = signed_op_s & bus.a[WIDTH-1];
  assign b_neg_s  = signed_op_s & bus.b[WIDTH-1];
  assign a_mag_s  = magnitude(bus.a, a_neg_s);
  assign b_mag_s  = magnitude(bus.b, b_neg_s);
  assign accept_s = bus.start & ~busy_r & legal_s;

  // Shift-add step: acc_r holds the running upper half, low_r the unconsumed multiplier bits
  logic [WIDTH:0]     mul_add_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_raw_s;
  logic [2*WIDTH-1:0] mul_res_s;
  assign mul_add_s = low_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}};
  assign mul_sum_s = acc_r + mul_add_s;
  assign mul_raw_s = {mul_sum_s, low_r[WIDTH-1:1]};
  assign mul_res_s = neg_q_r ? -mul_raw_s : mul_raw_s;

  // Restoring step: acc_r is the partial remainder, low_r shifts dividend out and quotient in
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH+1:0] div_trial_s;
  logic             div_ok_s;
  logic [WIDTH:0]   div_rem_s;
  logic [WIDTH-1:0] div_q_s;
  logic [WIDTH-1:0] div_q_res_s;
  logic [WIDTH-1:0] div_r_res_s;
  assign div_shift_s = {acc_r[WIDTH-1:0], low_r[WIDTH-1]};
  assign div_trial_s = {1'b0, div_shift_s} - {2'b00, operand_r};
  assign div_ok_s    = ~div_trial_s[WIDTH+1];
  assign div_rem_s   = div_ok_s ? div_trial_s[WIDTH:0] : div_shift_s;
  assign div_q_s     = {low_r[WIDTH-2:0], div_ok_s};
  // A zero divisor leaves the raw all-ones quotient and dividend magnitude untouched
  assign div_q_res_s = (neg_q_r & ~b_zero_r) ? -div_q_s : div_q_s;
  assign div_r_res_s = (neg_r_r & ~b_zero_r) ? -div_rem_s[WIDTH-1:0] : div_rem_s[WIDTH-1:0];

  // Sequencer FSM with datapath and registered status/HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= {CW{1'b0}};
      acc_r      <= {(WIDTH+1){1'b0}};
      low_r      <= {WIDTH{1'b0}};
      operand_r  <= {WIDTH{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      b_zero_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            div_zero_r <= 1'b0;
            neg_q_r    <= a_neg_s ^ b_neg_s;
            neg_r_r    <= a_neg_s;
            b_zero_r   <= (bus.b == {WIDTH{1'b0}});
            acc_r      <= {(WIDTH+1){1'b0}};
            count_r    <= COUNT_LOAD;
            case (bus.op)
              3'b100: begin
                hi_r   <= bus.a;
                done_r <= 1'b1;
              end
              3'b101: begin
                lo_r   <= bus.a;
                done_r <= 1'b1;
              end
              3'b000, 3'b010: begin
                state_r   <= MUL;
                busy_r    <= 1'b1;
                low_r     <= b_mag_s;
                operand_r <= a_mag_s;
              end
              3'b001, 3'b011: begin
                state_r   <= DIV;
                busy_r    <= 1'b1;
                low_r     <= a_mag_s;
                operand_r <= b_mag_s;
              end
              default: state_r <= IDLE;
            endcase
          end
        end
        MUL: begin
          count_r <= count_r - COUNT_ONE;
          acc_r   <= {1'b0, mul_sum_s[WIDTH:1]};
          low_r   <= {mul_sum_s[0], low_r[WIDTH-1:1]};
          if (count_r == COUNT_ONE) begin
            hi_r    <= mul_res_s[2*WIDTH-1:WIDTH];
            lo_r    <= mul_res_s[WIDTH-1:0];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        DIV: begin
          count_r <= count_r - COUNT_ONE;
          acc_r   <= div_rem_s;
          low_r   <= div_q_s;
          if (count_r == COUNT_ONE) begin
            hi_r       <= div_r_res_s;
            lo_r       <= div_q_res_s;
            div_zero_r <= b_zero_r;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.stall    = (bus.start | bus.rd_req) & busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic HI/LO model.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] m_hi, m_lo;
  logic         m_dz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted op; lat = cycles from accept edge to done
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
    longint unsigned ua, ub;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    lat = W;
    case (op)
      3'd0: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0; end
      3'd1: begin
        if (b == 0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; m_dz = 1'b0; end
      end
      3'd2: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0; end
      3'd3: begin
        if (b == 0) begin m_lo = '1; m_hi = a[31] ? -a : a; m_dz = 1'b1; end
        else begin
          sq = sa / sb; sr = sa % sb;
          p = sq; m_lo = p[31:0];
          p = sr; m_hi = p[31:0];
          m_dz = 1'b0;
        end
      end
      3'd4: begin m_hi = a; m_dz = 1'b0; lat = 0; end
      3'd5: begin m_lo = a; m_dz = 1'b0; lat = 0; end
      default: lat = -1;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int lat, cycles;
    model_op(op, a, b, lat);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.a = $urandom(); bus.b = $urandom();
    if (lat > 0) begin
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", name, bus.busy);
      else pass_cnt++;
    end
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 200) begin tick(); cycles++; end
    total_cnt++;
    if (cycles !== lat) $display("FAIL %s latency: got %0d want %0d", name, cycles, lat);
    else pass_cnt++;
    total_cnt++;
    if (bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL %s hilo: got %h_%h want %h_%h", name, bus.hi, bus.lo, m_hi, m_lo);
    else pass_cnt++;
    total_cnt++;
    if (bus.div_zero !== m_dz || bus.busy !== 1'b0)
      $display("FAIL %s status: got dz=%b busy=%b want dz=%b busy=0", name, bus.div_zero, bus.busy, m_dz);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL %s done_width: got %b want 0", name, bus.done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL reset_status: got busy=%b done=%b dz=%b stall=%b want 0000",
               bus.busy, bus.done, bus.div_zero, bus.stall);
    else pass_cnt++;
    total_cnt++;
    if (bus.hi !== '0 || bus.lo !== '0) $display("FAIL reset_hilo: got %h_%h want 0_0", bus.hi, bus.lo);
    else pass_cnt++;
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
  endtask

  task automatic test_mtxx_back_to_back();
    int lat;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hA5A5A5A5;
    model_op(3'd4, 32'hA5A5A5A5, 32'h0, lat);
    tick();
    total_cnt++;
    if (bus.done !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL mthi: got done=%b hi=%h lo=%h want 1 %h %h", bus.done, bus.hi, bus.lo, m_hi, m_lo);
    else pass_cnt++;
    bus.op = 3'd5; bus.a = 32'd5;
    model_op(3'd5, 32'd5, 32'h0, lat);
    tick();
    bus.start = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.hi !== 32'hA5A5A5A5 || bus.lo !== 32'd5)
      $display("FAIL mtlo: got done=%b hi=%h lo=%h want 1 a5a5a5a5 5", bus.done, bus.hi, bus.lo);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL mtxx_done_end: got %b want 0", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_multu();
    run_op("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total_cnt++;
    if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001)
      $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", bus.hi, bus.lo);
    else pass_cnt++;
    run_op("multu_zero", 3'd0, $urandom(), 32'h0);
    for (int i = 0; i < 6; i++) run_op("multu_rand", 3'd0, $urandom(), $urandom());
  endtask

  task automatic test_divu_stall();
    int lat;
    logic [W-1:0] old_hi;
    old_hi = m_hi;
    model_op(3'd1, 32'd100, 32'd7, lat);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j <= W; j++) begin
      if (j == 5) bus.rd_req = 1'b1;
      if (j == 10) begin bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEADBEEF; end
      #1;
      if (j >= 5) begin
        total_cnt++;
        if (bus.stall !== (j < W)) $display("FAIL stall_t%0d: got %b want %b", j, bus.stall, j < W);
        else pass_cnt++;
      end
      if (j == W - 1) begin
        total_cnt++;
        if (bus.hi !== old_hi || bus.done !== 1'b0)
          $display("FAIL start_while_busy: got hi=%h done=%b want %h 0", bus.hi, bus.done, old_hi);
        else pass_cnt++;
      end
      if (j < W) tick();
    end
    total_cnt++;
    if (bus.done !== 1'b1 || bus.lo !== 32'd14 || bus.hi !== 32'd2)
      $display("FAIL divu_100_7: got done=%b hi=%0d lo=%0d want 1 2 14", bus.done, bus.hi, bus.lo);
    else pass_cnt++;
    bus.rd_req = 1'b0;
    model_op(3'd4, 32'hDEADBEEF, 32'h0, lat);
    tick();
    bus.start = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL held_mthi: got done=%b hi=%h lo=%h want 1 %h %h", bus.done, bus.hi, bus.lo, m_hi, m_lo);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_divu();
    run_op("divu_zero", 3'd1, 32'h1234, 32'h0);
    run_op("mtlo_clears_dz", 3'd5, $urandom(), 32'h0);
    run_op("divu_small", 3'd1, $urandom(), $urandom_range(1, 15));
    run_op("divu_big_div", 3'd1, $urandom_range(0, 1000), $urandom());
    for (int i = 0; i < 5; i++) run_op("divu_rand", 3'd1, $urandom(), $urandom() >> $urandom_range(0, 31));
  endtask

  task automatic test_reset_mid();
    int done_seen;
    run_op("pre_reset_mul", 3'd0, $urandom() | 32'h1, $urandom() | 32'h1);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = $urandom(); bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < W + 4; i++) begin tick(); if (bus.done === 1'b1) done_seen++; end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL reset_no_done: got %0d pulses want 0", done_seen);
    else pass_cnt++;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h77;
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.start = 1'b0;
    tick();
    total_cnt++;
    if (bus.hi !== m_hi || bus.done !== 1'b0)
      $display("FAIL reset_beats_start: got hi=%h done=%b want %h 0", bus.hi, bus.done, m_hi);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
`ifdef MULDIV_SIGNED_EN
    logic [2:0] ops [2] = '{3'd6, 3'd7};
`else
    logic [2:0] ops [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
`endif
    foreach (ops[k]) begin
      bus.start = 1'b1; bus.op = ops[k]; bus.a = $urandom(); bus.b = $urandom();
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
          $display("FAIL illegal_op%0d: got done=%b busy=%b hi=%h lo=%h want 0 0 %h %h",
                   ops[k], bus.done, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        else pass_cnt++;
        tick();
      end
    end
  endtask

  task automatic test_signed();
`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2", 3'd3, -32'sd7, 32'd2);
    total_cnt++;
    if (bus.lo !== -32'sd3 || bus.hi !== -32'sd1)
      $display("FAIL div_m7_2_const: got %h_%h want ffffffff_fffffffd", bus.hi, bus.lo);
    else pass_cnt++;
    run_op("mult_m3_4", 3'd2, -32'sd3, 32'd4);
    run_op("div_zero_signed", 3'd3, -32'sd50, 32'd0);
    for (int i = 0; i < 4; i++) run_op("mult_rand", 3'd2, $urandom(), $urandom());
    for (int i = 0; i < 4; i++) run_op("div_rand", 3'd3, $urandom(), $urandom() >> $urandom_range(0, 28));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.rd_req = 1'b0;
    reset = 1'b1;
    test_reset();
    test_mtxx_back_to_back();
    test_multu();
    test_divu_stall();
    test_divu();
    test_illegal();
    test_signed();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
